// File: rtl/rv_mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch and MEM stages.
// Data has priority; a saturating counter lets a starved fetch through.
module rv_mem_arbiter #(
    parameter int unsigned StarveLimit = 4,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    input  logic            if_flush_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [3:0]      d_be_i,
    input  logic [XLEN-1:0] d_wdata_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ready_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_I,
        WAIT_D
    } state_t;

    localparam logic [3:0] Limit = 4'(StarveLimit);

    state_t     state_q;
    logic [3:0] starve_q;
    logic       drop_q;
    logic       store_q;

    logic issue_ok;
    logic pick_i;
    logic pick_d;
    logic rsp;

    always_comb begin
        issue_ok = !rst_i && ((state_q == IDLE) || mem_rvalid_i);
        pick_i   = if_req_i && (!d_req_i || (starve_q == Limit));
        pick_d   = d_req_i && !pick_i;
        // Responses seen while idle belong to nobody (e.g. pre-reset traffic).
        rsp      = !rst_i && mem_rvalid_i && (state_q != IDLE);
    end

    always_comb begin
        mem_req_o   = issue_ok && (if_req_i || d_req_i);
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = 4'h0;
        mem_wdata_o = '0;
        unique case (1'b1)
            mem_req_o && pick_i: begin
                mem_addr_o = if_addr_i;
                mem_be_o   = 4'hF;
            end
            mem_req_o && pick_d: begin
                mem_we_o    = d_we_i;
                mem_addr_o  = d_addr_i;
                mem_be_o    = d_be_i;
                mem_wdata_o = d_wdata_i;
            end
            default: ;
        endcase
        if_gnt_o = mem_req_o && pick_i && mem_ready_i;
        d_gnt_o  = mem_req_o && pick_d && mem_ready_i;
    end

    always_comb begin
        d_rvalid_o  = rsp && (state_q == WAIT_D);
        d_rdata_o   = (d_rvalid_o && !store_q) ? mem_rdata_i : '0;
        if_rvalid_o = rsp && (state_q == WAIT_I) && !drop_q && !if_flush_i;
        if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
            drop_q   <= 1'b0;
            store_q  <= 1'b0;
        end else begin
            if (if_gnt_o) begin
                state_q <= WAIT_I;
            end else if (d_gnt_o) begin
                state_q <= WAIT_D;
            end else if (rsp) begin
                state_q <= IDLE;
            end

            if (d_gnt_o) begin
                store_q <= d_we_i;
            end

            // A flush on the granting cycle targets the new fetch.
            if (if_gnt_o && if_flush_i) begin
                drop_q <= 1'b1;
            end else if (rsp && (state_q == WAIT_I)) begin
                drop_q <= 1'b0;
            end else if ((state_q == WAIT_I) && if_flush_i) begin
                drop_q <= 1'b1;
            end

            if (if_req_i && !if_gnt_o) begin
                if (starve_q != Limit) begin
                    starve_q <= starve_q + 4'd1;
                end
            end else begin
                starve_q <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: vector table, directed
// sequences, and randomized traffic against a transaction-queue model.
module tb_rv_mem_arbiter;

    localparam int LIMIT = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_flush;
    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [3:0]      d_be;
    logic [XLEN-1:0] d_wdata;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;

    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [XLEN-1:0] if_rdata_o;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [3:0]      mem_be_o;
    logic [XLEN-1:0] mem_wdata_o;

    rv_mem_arbiter #(
        .StarveLimit(LIMIT),
        .XLEN       (XLEN)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_flush_i  (if_flush),
        .if_gnt_o    (if_gnt_o),
        .if_rvalid_o (if_rvalid_o),
        .if_rdata_o  (if_rdata_o),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_be_i      (d_be),
        .d_wdata_i   (d_wdata),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_be_o    (mem_be_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the outstanding transaction is a queue entry that
    // remembers its owner, whether it is a store, and whether it was flushed.
    typedef struct {
        bit fetch;
        bit store;
        bit dropped;
    } txn_t;

    txn_t pend[$];
    int   starve;

    bit          e_if_gnt, e_d_gnt, e_req, e_we, e_if_rv, e_d_rv;
    logic [31:0] e_addr, e_wdata, e_if_data, e_d_data;
    logic [3:0]  e_be;

    task automatic model_eval();
        bit   free;
        bit   fetch_turn;
        txn_t h;
        e_if_gnt = 0; e_d_gnt = 0; e_req = 0; e_we = 0;
        e_if_rv = 0; e_d_rv = 0;
        e_addr = '0; e_wdata = '0; e_be = '0;
        e_if_data = '0; e_d_data = '0;
        if (rst) return;
        if (if_flush && pend.size() > 0 && pend[0].fetch) begin
            h = pend[0];
            h.dropped = 1;
            pend[0] = h;
        end
        free = (pend.size() == 0) || mem_rvalid;
        fetch_turn = if_req && (!d_req || starve >= LIMIT);
        if (free && fetch_turn) begin
            e_req = 1; e_addr = if_addr; e_be = 4'hF;
            e_if_gnt = mem_ready;
        end else if (free && d_req) begin
            e_req = 1; e_we = d_we; e_addr = d_addr;
            e_be = d_be; e_wdata = d_wdata;
            e_d_gnt = mem_ready;
        end
        if (pend.size() > 0 && mem_rvalid) begin
            if (pend[0].fetch) begin
                e_if_rv = !pend[0].dropped;
                e_if_data = mem_rdata;
            end else begin
                e_d_rv = 1;
                e_d_data = pend[0].store ? 32'h0 : mem_rdata;
            end
        end
    endtask

    task automatic model_commit();
        txn_t t;
        if (rst) begin
            pend.delete();
            starve = 0;
            return;
        end
        if (pend.size() > 0 && mem_rvalid) void'(pend.pop_front());
        if (e_if_gnt) begin
            t.fetch = 1; t.store = 0; t.dropped = if_flush;
            pend.push_back(t);
        end else if (e_d_gnt) begin
            t.fetch = 0; t.store = d_we; t.dropped = 0;
            pend.push_back(t);
        end
        if (if_req && !e_if_gnt) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
        else starve = 0;
    endtask

    task automatic compare_all();
        check1("if_gnt", if_gnt_o, e_if_gnt);
        check1("d_gnt", d_gnt_o, e_d_gnt);
        check1("mem_req", mem_req_o, e_req);
        check1("if_rvalid", if_rvalid_o, e_if_rv);
        check1("d_rvalid", d_rvalid_o, e_d_rv);
        check1("both_rvalid", if_rvalid_o & d_rvalid_o, 1'b0);
        if (rst || e_req) begin
            check1("mem_we", mem_we_o, e_we);
            check32("mem_addr", mem_addr_o, e_addr);
            check32("mem_be", {28'h0, mem_be_o}, {28'h0, e_be});
            check32("mem_wdata", mem_wdata_o, e_wdata);
        end
        if (rst || e_if_rv) check32("if_rdata", if_rdata_o, e_if_data);
        if (rst || e_d_rv) check32("d_rdata", d_rdata_o, e_d_data);
    endtask

    task automatic eval_cycle();
        #1;
        model_eval();
        compare_all();
    endtask

    task automatic end_cycle();
        model_commit();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = '0; d_be = '0; d_wdata = '0;
        mem_ready = 1; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        eval_cycle();
        end_cycle();
        rst = 0;
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [3:0]  d_be;
        logic [31:0] d_wdata;
        logic        ready;
        logic        x_if_gnt;
        logic        x_d_gnt;
        logic        x_req;
        logic        x_we;
        logic [31:0] x_addr;
        logic [3:0]  x_be;
        logic [31:0] x_wdata;
    } vec_t;

    vec_t tbl[6];
    int   mem_wait;

    initial begin
        rst = 1;
        clear_inputs();
        starve = 0;
        mem_wait = 0;

        // if_req if_addr d_req d_we d_addr d_be d_wdata ready |
        // if_gnt d_gnt req we addr be wdata
        tbl[0] = '{1, 32'h40, 0, 0, 32'h0, 4'h0, 32'h0, 1,
                   1, 0, 1, 0, 32'h40, 4'hF, 32'h0};
        tbl[1] = '{0, 32'h0, 1, 1, 32'h200, 4'h5, 32'hA5A5A5A5, 1,
                   0, 1, 1, 1, 32'h200, 4'h5, 32'hA5A5A5A5};
        tbl[2] = '{1, 32'h44, 1, 0, 32'h300, 4'hF, 32'h0, 1,
                   0, 1, 1, 0, 32'h300, 4'hF, 32'h0};
        tbl[3] = '{1, 32'h48, 1, 1, 32'h304, 4'hC, 32'h11223344, 0,
                   0, 0, 1, 1, 32'h304, 4'hC, 32'h11223344};
        tbl[4] = '{0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 1,
                   0, 0, 0, 0, 32'h0, 4'h0, 32'h0};
        tbl[5] = '{1, 32'h4C, 0, 0, 32'h0, 4'h0, 32'h0, 0,
                   0, 0, 1, 0, 32'h4C, 4'hF, 32'h0};

        @(negedge clk);
        eval_cycle();
        check1("rst_req", mem_req_o, 1'b0);
        end_cycle();
        rst = 0;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            if_req = tbl[i].if_req; if_addr = tbl[i].if_addr;
            d_req = tbl[i].d_req; d_we = tbl[i].d_we;
            d_addr = tbl[i].d_addr; d_be = tbl[i].d_be;
            d_wdata = tbl[i].d_wdata; mem_ready = tbl[i].ready;
            eval_cycle();
            check1($sformatf("T%0d_if_gnt", i), if_gnt_o, tbl[i].x_if_gnt);
            check1($sformatf("T%0d_d_gnt", i), d_gnt_o, tbl[i].x_d_gnt);
            check1($sformatf("T%0d_req", i), mem_req_o, tbl[i].x_req);
            if (tbl[i].x_req) begin
                check1($sformatf("T%0d_we", i), mem_we_o, tbl[i].x_we);
                check32($sformatf("T%0d_addr", i), mem_addr_o, tbl[i].x_addr);
                check32($sformatf("T%0d_be", i), {28'h0, mem_be_o},
                        {28'h0, tbl[i].x_be});
                check32($sformatf("T%0d_wdata", i), mem_wdata_o, tbl[i].x_wdata);
            end
            end_cycle();
        end

        // Fetch stream on a single-cycle memory.
        do_reset();
        if_req = 1; if_addr = 32'h0;
        eval_cycle();
        check1("A_gnt0", if_gnt_o, 1'b1);
        check32("A_addr0", mem_addr_o, 32'h0);
        end_cycle();
        if_addr = 32'h4; mem_rvalid = 1; mem_rdata = 32'h00000093;
        eval_cycle();
        check1("A_gnt1", if_gnt_o, 1'b1);
        check32("A_addr1", mem_addr_o, 32'h4);
        check1("A_rv0", if_rvalid_o, 1'b1);
        check32("A_data0", if_rdata_o, 32'h00000093);
        end_cycle();
        if_addr = 32'h8; mem_rdata = 32'h00100113;
        eval_cycle();
        check1("A_gnt2", if_gnt_o, 1'b1);
        check1("A_rv1", if_rvalid_o, 1'b1);
        check32("A_data1", if_rdata_o, 32'h00100113);
        end_cycle();
        if_req = 0; mem_rdata = 32'h00200193;
        eval_cycle();
        check1("A_rv2", if_rvalid_o, 1'b1);
        check32("A_data2", if_rdata_o, 32'h00200193);
        check1("A_nognt", if_gnt_o, 1'b0);
        end_cycle();
        mem_rvalid = 0;

        // Store beats a concurrent fetch; fetch follows on the response.
        do_reset();
        if_req = 1; if_addr = 32'h10;
        d_req = 1; d_we = 1; d_addr = 32'h100;
        d_be = 4'b0011; d_wdata = 32'hDEADBEEF;
        eval_cycle();
        check1("B_d_gnt", d_gnt_o, 1'b1);
        check1("B_if_wait", if_gnt_o, 1'b0);
        check1("B_we", mem_we_o, 1'b1);
        check32("B_be", {28'h0, mem_be_o}, 32'h3);
        check32("B_wdata", mem_wdata_o, 32'hDEADBEEF);
        end_cycle();
        d_req = 0; d_we = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
        eval_cycle();
        check1("B_d_rv", d_rvalid_o, 1'b1);
        check32("B_d_rdata", d_rdata_o, 32'h0);
        check1("B_if_gnt", if_gnt_o, 1'b1);
        check32("B_if_addr", mem_addr_o, 32'h10);
        check32("B_if_be", {28'h0, mem_be_o}, 32'hF);
        end_cycle();
        if_req = 0; mem_rdata = 32'h00000013;
        eval_cycle();
        check1("B_if_rv", if_rvalid_o, 1'b1);
        check1("B_d_quiet", d_rvalid_o, 1'b0);
        end_cycle();
        mem_rvalid = 0;

        // Starvation guard: four data grants, then one fetch, repeating.
        do_reset();
        if_req = 1; if_addr = 32'h80;
        d_req = 1; d_we = 0; d_addr = 32'h400; d_be = 4'hF;
        for (int i = 0; i < 10; i++) begin
            mem_rvalid = (i != 0);
            mem_rdata = 32'(i);
            eval_cycle();
            check1($sformatf("C_if_gnt%0d", i), if_gnt_o, (i % 5) == 4);
            check1($sformatf("C_d_gnt%0d", i), d_gnt_o, (i % 5) != 4);
            end_cycle();
        end
        if_req = 0; d_req = 0;
        eval_cycle();
        end_cycle();
        mem_rvalid = 0;

        // Flush while a fetch is outstanding drops its response.
        do_reset();
        if_req = 1; if_addr = 32'h20;
        eval_cycle();
        check1("D_gnt", if_gnt_o, 1'b1);
        end_cycle();
        if_req = 0; if_flush = 1;
        eval_cycle(); end_cycle();
        if_flush = 0;
        eval_cycle(); end_cycle();
        eval_cycle(); end_cycle();
        mem_rvalid = 1; mem_rdata = 32'h00000013;
        eval_cycle();
        check1("D_dropped", if_rvalid_o, 1'b0);
        end_cycle();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h24;
        eval_cycle();
        check1("D_gnt2", if_gnt_o, 1'b1);
        end_cycle();
        if_req = 0; mem_rvalid = 1; mem_rdata = 32'h00100093;
        eval_cycle();
        check1("D_rv", if_rvalid_o, 1'b1);
        check32("D_data", if_rdata_o, 32'h00100093);
        end_cycle();
        mem_rvalid = 0;

        // Memory back-pressure holds the request without a grant.
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h500; d_be = 4'hF; mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            eval_cycle();
            check1($sformatf("E_req%0d", i), mem_req_o, 1'b1);
            check1($sformatf("E_nognt%0d", i), d_gnt_o, 1'b0);
            end_cycle();
        end
        mem_ready = 1;
        eval_cycle();
        check1("E_gnt", d_gnt_o, 1'b1);
        end_cycle();
        d_req = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        eval_cycle();
        check1("E_rv", d_rvalid_o, 1'b1);
        check32("E_data", d_rdata_o, 32'hCAFEF00D);
        end_cycle();
        mem_rvalid = 0;

        // Reset abandons an outstanding data access.
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h600; d_be = 4'hF; d_wdata = 32'h55;
        eval_cycle();
        check1("F_gnt", d_gnt_o, 1'b1);
        end_cycle();
        rst = 1;
        eval_cycle();
        check1("F_rst_outs", |{if_gnt_o, if_rvalid_o, if_rdata_o, d_gnt_o,
               d_rvalid_o, d_rdata_o, mem_req_o, mem_we_o, mem_addr_o,
               mem_be_o, mem_wdata_o}, 1'b0);
        end_cycle();
        rst = 0; d_req = 0; mem_rvalid = 1; mem_rdata = 32'h77;
        eval_cycle();
        check1("F_d_rv", d_rvalid_o, 1'b0);
        check1("F_if_rv", if_rvalid_o, 1'b0);
        check1("F_req", mem_req_o, 1'b0);
        end_cycle();
        mem_rvalid = 0; if_req = 1; if_addr = 32'h30;
        eval_cycle();
        check1("F_idle_gnt", if_gnt_o, 1'b1);
        end_cycle();
        if_req = 0; mem_rvalid = 1;
        eval_cycle(); end_cycle();
        mem_rvalid = 0;

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!if_req && ($urandom_range(0, 2) == 0)) begin
                if_req = 1;
                if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (!d_req && ($urandom_range(0, 2) == 0)) begin
                d_req = 1;
                d_we = 1'($urandom());
                d_addr = $urandom();
                d_be = 4'($urandom());
                d_wdata = $urandom();
            end
            if_flush = ($urandom_range(0, 5) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            mem_rdata = $urandom();
            if (pend.size() > 0) begin
                if (mem_wait == 0) begin
                    mem_rvalid = 1;
                end else begin
                    mem_rvalid = 0;
                    mem_wait--;
                end
            end else begin
                mem_rvalid = ($urandom_range(0, 7) == 0);
            end
            eval_cycle();
            end_cycle();
            if (e_if_gnt) if_req = 0;
            if (e_d_gnt) d_req = 0;
            if (e_if_gnt || e_d_gnt) mem_wait = $urandom_range(0, 2);
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
